sc_lane_scroller: RTL and testbench
===================================

Name: sc_lane_scroller

Overview:
- Parametrised lane register for the vehicle/obstacle rows of the game.
- Loads a per-level bit pattern and rotates it circularly at a per-level period, in a selectable direction, with pause and clear control.
- Its parallel output drives one lane row of the matrix display; its tick output feeds collision and scoring logic.
- Successor to the fixed 8-bit, three-speed lane register: width, level count and periods are parameters, and direction, pause, freeze and tick are new.

Parameters:
- DATAWIDTH_BUS, 16, lane width in cells (≥2).
- DATAWIDTH_NVL, 2, level index width; the number of levels is 2**DATAWIDTH_NVL (this block supports 4).
- DATAWIDTH_PERIOD, 24, width of the shift-period counter.
- NV_PATTERN_0..NV_PATTERN_3, DATAWIDTH_BUS, 0, pattern loaded for level 0..3.
- NV_PERIOD_0..NV_PERIOD_3, DATAWIDTH_PERIOD, 0, clock cycles per shift for level 0..3; 0 means the lane is frozen.

Ports:
- SC_LANE_SCROLLER_CLOCK  in  1  system clock.
- SC_LANE_SCROLLER_RESET  in  1  synchronous reset, active-low.
- SC_LANE_SCROLLER_START_IN  in  1  load the pattern of the selected level and start.
- SC_LANE_SCROLLER_CLEAR_IN  in  1  blank the lane and go idle.
- SC_LANE_SCROLLER_PAUSE_IN  in  1  level-sensitive hold.
- SC_LANE_SCROLLER_DIR_IN  in  1  0 = rotate left (toward MSB), 1 = rotate right.
- SC_LANE_SCROLLER_NVL_IN  in  DATAWIDTH_NVL  level select, sampled on START only.
- SC_LANE_SCROLLER_DATAPARALLEL_OUT  out  DATAWIDTH_BUS  lane cells.
- SC_LANE_SCROLLER_TICK_OUT  out  1  one-cycle pulse, registered, coincident with each data shift.
- SC_LANE_SCROLLER_NVL_OUT  out  DATAWIDTH_NVL  latched active level.
- SC_LANE_SCROLLER_RUNNING_OUT  out  1  high in state RUN.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Reset is sampled only on the SC_LANE_SCROLLER_CLOCK rising edge while SC_LANE_SCROLLER_RESET=0.
- Reset values: DATAPARALLEL_OUT=0, TICK_OUT=0, NVL_OUT=0, RUNNING_OUT=0, counter=0, state=IDLE.
- States:
  - IDLE: blank, no shifting.
  - RUN: counting and shifting.
  - PAUSE: data and counter held.
  - FROZEN: pattern shown, period=0, no shifting.
- Priority at each edge: reset > CLEAR > START > PAUSE > shift.
- CLEAR (any state): next edge gives data=0, state=IDLE, TICK=0. NVL_OUT is held.
- START (any state, including mid-run or paused):
  - Next edge: data=NV_PATTERN[NVL_IN] and NVL_OUT=NVL_IN.
  - If NV_PERIOD[NVL_IN]=0: state=FROZEN.
  - Otherwise: counter=P-1 and state=RUN, or state=PAUSE if PAUSE_IN=1 on that edge.
  - START never produces a TICK.
- RUN, PAUSE_IN=0:
  - counter≠0: decrement.
  - counter=0: rotate one cell per DIR_IN (sampled on that edge), reload counter=P-1, TICK_OUT=1 for exactly that cycle.
  - First shift lands exactly P edges after the load edge; later shifts every P edges. P=1 means a shift on every edge.
- Rotation is circular with no cell loss:
  - Left: {d[W-2:0], d[W-1]}.
  - Right: {d[0], d[W-1:1]}.
- Pause:
  - PAUSE_IN=1 in RUN: state=PAUSE; counter and data frozen; no tick on that edge, even if counter=0.
  - PAUSE_IN=0 in PAUSE: state=RUN; counting resumes from the held value, so total RUN cycles between shifts is still P.
- FROZEN: PAUSE_IN is ignored. Only START, CLEAR or reset leave the state.
- DIR change mid-run affects only the next shift. The counter is not restarted.
- Period arithmetic is unsigned, no overflow: counter ≤ P-1 < 2**DATAWIDTH_PERIOD.
- Reset asserted mid-run takes effect on the next edge and overrides a simultaneous START or shift.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, PAUSE, FROZEN, 2-bit);
  - rotate-direction constants (DIR_LEFT=0, DIR_RIGHT=1);
  - a level-table lookup function mapping NVL to pattern/period from the parameters.
- One sub-module, sc_lane_period_counter:
  - inputs: load, load value, enable;
  - outputs: zero-detect and reload strobe;
  - holds its value when enable=0.
- The top keeps the FSM, the rotate register and the output registers.

Test Plan:
Bench uses W=8, NV_PATTERN_1=8'b1100_0001, NV_PERIOD_1=3, NV_PERIOD_2=0, NV_PERIOD_3=1.
- Reset then START with NVL=1, DIR=0 → data=C1h on load edge, RUNNING=1; edge+3 gives 83h with one TICK; edge+6 gives 07h. No tick on other edges.
- DIR=1 with the same load → edge+3 gives E0h, edge+6 gives 70h. Toggling DIR between shifts flips only the next shift.
- PAUSE held for 5 cycles starting one edge after load → data stays C1h, no TICK. After release, the shift occurs 2 RUN edges later. PAUSE asserted on a counter=0 edge suppresses that tick.
- START with NVL=2 (period 0) → data=pattern 2, state FROZEN, RUNNING=0, no TICK for 100 cycles; PAUSE has no effect.
- START with NVL=3 → shift and TICK on every edge; after 8 shifts data returns to pattern 3 (wrap check).
- START and CLEAR asserted on the same edge → data=0, IDLE. Reset low mid-run with START high → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/sc_lane_scroller_pkg.sv
// Shared types and helpers for the lane scroller: FSM state encoding,
// rotate-direction constants and the per-level table lookup.
package sc_lane_scroller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_FROZEN = 2'd3
    } lane_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Level entries travel as wide words so one function serves any pattern or period width.
    localparam int LEVEL_WORD_W = 64;
    typedef logic [LEVEL_WORD_W-1:0] level_word_t;

    function automatic level_word_t level_lookup(
        input logic [1:0]  nvl,
        input level_word_t entry_0,
        input level_word_t entry_1,
        input level_word_t entry_2,
        input level_word_t entry_3
    );
        level_word_t result;
        case (nvl)
            2'd0:    result = entry_0;
            2'd1:    result = entry_1;
            2'd2:    result = entry_2;
            default: result = entry_3;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sc_lane_period_counter.sv
// Down-counter that paces lane shifts: flags zero and reloads itself when
// it expires while enabled; holds its value while disabled.
module sc_lane_period_counter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero,
    output logic             reload
);

    logic [WIDTH-1:0] count;

    assign zero   = (count == '0);
    assign reload = enable && zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load || reload) begin
            count <= load_value;
        end else if (enable) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_lane_scroller.sv
// Lane register for one display row: loads a per-level pattern and rotates
// it circularly at a per-level period, with pause, freeze and clear control.
module sc_lane_scroller
    import sc_lane_scroller_pkg::*;
#(
    parameter int                          DATAWIDTH_BUS    = 16,
    parameter int                          DATAWIDTH_NVL    = 2,
    parameter int                          DATAWIDTH_PERIOD = 24,
    parameter logic [DATAWIDTH_BUS-1:0]    NV_PATTERN_0     = '0,
    parameter logic [DATAWIDTH_BUS-1:0]    NV_PATTERN_1     = '0,
    parameter logic [DATAWIDTH_BUS-1:0]    NV_PATTERN_2     = '0,
    parameter logic [DATAWIDTH_BUS-1:0]    NV_PATTERN_3     = '0,
    parameter logic [DATAWIDTH_PERIOD-1:0] NV_PERIOD_0      = '0,
    parameter logic [DATAWIDTH_PERIOD-1:0] NV_PERIOD_1      = '0,
    parameter logic [DATAWIDTH_PERIOD-1:0] NV_PERIOD_2      = '0,
    parameter logic [DATAWIDTH_PERIOD-1:0] NV_PERIOD_3      = '0
) (
    input  logic                     SC_LANE_SCROLLER_CLOCK,
    input  logic                     SC_LANE_SCROLLER_RESET,
    input  logic                     SC_LANE_SCROLLER_START_IN,
    input  logic                     SC_LANE_SCROLLER_CLEAR_IN,
    input  logic                     SC_LANE_SCROLLER_PAUSE_IN,
    input  logic                     SC_LANE_SCROLLER_DIR_IN,
    input  logic [DATAWIDTH_NVL-1:0] SC_LANE_SCROLLER_NVL_IN,
    output logic [DATAWIDTH_BUS-1:0] SC_LANE_SCROLLER_DATAPARALLEL_OUT,
    output logic                     SC_LANE_SCROLLER_TICK_OUT,
    output logic [DATAWIDTH_NVL-1:0] SC_LANE_SCROLLER_NVL_OUT,
    output logic                     SC_LANE_SCROLLER_RUNNING_OUT
);

    lane_state_t                 state;
    logic [DATAWIDTH_BUS-1:0]    data;
    logic [DATAWIDTH_BUS-1:0]    rotated;
    logic [DATAWIDTH_BUS-1:0]    sel_pattern;
    logic [DATAWIDTH_PERIOD-1:0] sel_period;
    logic [DATAWIDTH_PERIOD-1:0] period_m1;
    logic [DATAWIDTH_PERIOD-1:0] counter_load_value;
    logic                        tick;
    logic                        running;
    logic [DATAWIDTH_NVL-1:0]    nvl_q;
    logic                        start;
    logic                        clear;
    logic                        pause;
    logic                        counter_enable;
    logic                        counter_zero;
    logic                        counter_reload;

    assign start = SC_LANE_SCROLLER_START_IN;
    assign clear = SC_LANE_SCROLLER_CLEAR_IN;
    assign pause = SC_LANE_SCROLLER_PAUSE_IN;

    assign sel_pattern = DATAWIDTH_BUS'(level_lookup(SC_LANE_SCROLLER_NVL_IN,
        LEVEL_WORD_W'(NV_PATTERN_0), LEVEL_WORD_W'(NV_PATTERN_1),
        LEVEL_WORD_W'(NV_PATTERN_2), LEVEL_WORD_W'(NV_PATTERN_3)));
    assign sel_period = DATAWIDTH_PERIOD'(level_lookup(SC_LANE_SCROLLER_NVL_IN,
        LEVEL_WORD_W'(NV_PERIOD_0), LEVEL_WORD_W'(NV_PERIOD_1),
        LEVEL_WORD_W'(NV_PERIOD_2), LEVEL_WORD_W'(NV_PERIOD_3)));

    assign rotated = (SC_LANE_SCROLLER_DIR_IN == DIR_LEFT)
                   ? {data[DATAWIDTH_BUS-2:0], data[DATAWIDTH_BUS-1]}
                   : {data[0], data[DATAWIDTH_BUS-1:1]};

    // The release edge out of PAUSE already counts, so P counting edges separate shifts.
    assign counter_enable = ((state == ST_RUN) || (state == ST_PAUSE))
                          && !pause && !clear && !start;
    assign counter_load_value = start ? (sel_period - DATAWIDTH_PERIOD'(1)) : period_m1;

    sc_lane_period_counter #(
        .WIDTH(DATAWIDTH_PERIOD)
    ) u_period_counter (
        .clk        (SC_LANE_SCROLLER_CLOCK),
        .rst_n      (SC_LANE_SCROLLER_RESET),
        .load       (start && !clear),
        .load_value (counter_load_value),
        .enable     (counter_enable),
        .zero       (counter_zero),
        .reload     (counter_reload)
    );

    always_ff @(posedge SC_LANE_SCROLLER_CLOCK) begin
        if (!SC_LANE_SCROLLER_RESET) begin
            state     <= ST_IDLE;
            data      <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            nvl_q     <= '0;
            period_m1 <= '0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                data    <= '0;
                state   <= ST_IDLE;
                running <= 1'b0;
            end else if (start) begin
                data      <= sel_pattern;
                nvl_q     <= SC_LANE_SCROLLER_NVL_IN;
                period_m1 <= sel_period - DATAWIDTH_PERIOD'(1);
                if (sel_period == '0) begin
                    state   <= ST_FROZEN;
                    running <= 1'b0;
                end else if (pause) begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                end else begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
                if (counter_reload) begin
                    data <= rotated;
                    tick <= 1'b1;
                end
            end
        end
    end

    assign SC_LANE_SCROLLER_DATAPARALLEL_OUT = data;
    assign SC_LANE_SCROLLER_TICK_OUT         = tick;
    assign SC_LANE_SCROLLER_NVL_OUT          = nvl_q;
    assign SC_LANE_SCROLLER_RUNNING_OUT      = running;

endmodule

// File: tb/tb_sc_lane_scroller.sv
// Directed bench for sc_lane_scroller: a cycle-by-cycle vector table plus
// hand-written frozen-level and wrap-around sequences.
module tb_sc_lane_scroller;

    localparam int W  = 8;
    localparam int NW = 2;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic          pause;
    logic          dir;
    logic [NW-1:0] nvl;
    logic [W-1:0]  data;
    logic          tick;
    logic [NW-1:0] nvl_o;
    logic          running;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sc_lane_scroller #(
        .DATAWIDTH_BUS    (W),
        .DATAWIDTH_NVL    (NW),
        .DATAWIDTH_PERIOD (PW),
        .NV_PATTERN_0     (8'h81),
        .NV_PATTERN_1     (8'b1100_0001),
        .NV_PATTERN_2     (8'h3C),
        .NV_PATTERN_3     (8'h96),
        .NV_PERIOD_0      (8'd5),
        .NV_PERIOD_1      (8'd3),
        .NV_PERIOD_2      (8'd0),
        .NV_PERIOD_3      (8'd1)
    ) dut (
        .SC_LANE_SCROLLER_CLOCK            (clock),
        .SC_LANE_SCROLLER_RESET            (rst_n),
        .SC_LANE_SCROLLER_START_IN         (start),
        .SC_LANE_SCROLLER_CLEAR_IN         (clear),
        .SC_LANE_SCROLLER_PAUSE_IN         (pause),
        .SC_LANE_SCROLLER_DIR_IN           (dir),
        .SC_LANE_SCROLLER_NVL_IN           (nvl),
        .SC_LANE_SCROLLER_DATAPARALLEL_OUT (data),
        .SC_LANE_SCROLLER_TICK_OUT         (tick),
        .SC_LANE_SCROLLER_NVL_OUT          (nvl_o),
        .SC_LANE_SCROLLER_RUNNING_OUT      (running)
    );

    typedef struct {
        logic          rst_n;
        logic          start;
        logic          clear;
        logic          pause;
        logic          dir;
        logic [NW-1:0] nvl;
        logic [W-1:0]  exp_data;
        logic          exp_tick;
        logic [NW-1:0] exp_nvl;
        logic          exp_run;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic s, input logic c, input logic p,
                          input logic d, input logic [NW-1:0] n, input logic [W-1:0] ed,
                          input logic et, input logic [NW-1:0] en, input logic er);
        vec_t v;
        v.rst_n = r; v.start = s; v.clear = c; v.pause = p; v.dir = d; v.nvl = n;
        v.exp_data = ed; v.exp_tick = et; v.exp_nvl = en; v.exp_run = er;
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic applyStimulus(input logic r, input logic s, input logic c, input logic p,
                                 input logic d, input logic [NW-1:0] n);
        rst_n = r; start = s; clear = c; pause = p; dir = d; nvl = n;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] ed, input logic et,
                               input logic [NW-1:0] en, input logic er);
        checks++;
        if (data !== ed || tick !== et || nvl_o !== en || running !== er) begin
            errors++;
            $display("[TB] FAIL %s: got data=%h tick=%b nvl=%0d run=%b, expected data=%h tick=%b nvl=%0d run=%b",
                     tag, data, tick, nvl_o, running, ed, et, en, er);
        end
    endtask

    initial begin
        logic [W-1:0] exp_data;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; pause = 1'b0; dir = 1'b0; nvl = '0;

        //     rst st cl pa di nvl  data  tk nvl run
        addVec(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        // left rotation, period 3
        addVec(1, 1, 0, 0, 0, 1, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 1, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h07, 1, 1, 1);
        // right rotation, then direction toggled between shifts
        addVec(1, 1, 0, 0, 1, 1, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hE0, 1, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hE0, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hE0, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 1, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 0, 8'hE0, 1, 1, 1);
        // pause for 5 edges right after load
        addVec(1, 1, 0, 0, 0, 1, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 1, 0, 0, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 1, 0, 0, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 1, 0, 0, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 1, 0, 0, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 1, 0, 0, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 1, 1, 1);
        // pause on the counter-expiry edge suppresses that tick
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'h83, 0, 1, 1);
        addVec(1, 0, 0, 1, 0, 0, 8'h83, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'h07, 1, 1, 1);
        // start while pause held lands in PAUSE
        addVec(1, 1, 0, 1, 0, 1, 8'hC1, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        // clear, and clear beating a simultaneous start
        addVec(1, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        addVec(1, 1, 1, 0, 0, 3, 8'h00, 0, 1, 0);
        addVec(1, 1, 0, 0, 0, 0, 8'h81, 0, 0, 1);
        addVec(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
        // reset beats a simultaneous start mid-run
        addVec(1, 1, 0, 0, 0, 1, 8'hC1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 8'hC1, 0, 1, 1);
        addVec(0, 1, 0, 0, 0, 3, 8'h00, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].start, vecs[i].clear, vecs[i].pause,
                          vecs[i].dir, vecs[i].nvl);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_tick,
                        vecs[i].exp_nvl, vecs[i].exp_run);
        end

        // Frozen level: pattern shown, pause and direction ignored for 100 cycles
        applyStimulus(1, 1, 0, 0, 0, 2);
        checkOutput("frozen_load", 8'h3C, 0, 2, 0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 0, 0, (i % 3) == 0, i[1], 0);
            checkOutput($sformatf("frozen_hold%0d", i), 8'h3C, 0, 2, 0);
        end

        // Period 1: a shift on every edge, back to the pattern after W shifts
        applyStimulus(1, 1, 0, 0, 0, 3);
        checkOutput("wrap_load", 8'h96, 0, 3, 1);
        exp_data = 8'h96;
        for (int k = 0; k < W; k++) begin
            exp_data = {exp_data[W-2:0], exp_data[W-1]};
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("wrap_shift%0d", k), exp_data, 1, 3, 1);
        end
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("wrap_right", 8'h4B, 1, 3, 1);
        applyStimulus(1, 0, 0, 1, 1, 0);
        checkOutput("p1_pause", 8'h4B, 0, 3, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("p1_resume", 8'hA5, 1, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
